// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use and data-memory stall controller for the 5-stage LC-3b pipeline.
//
// Handshake semantics: imem_resp / dmem_resp are single-cycle "access complete" strobes
// sampled in the same cycle as the request; every stall control is a zero-latency
// combinational function of the pipeline-register inputs and the FSM state.
//
// Optional macro STALL_PERF_EN adds saturating load-use and dmem-stall counters;
// with it undefined no counter flops exist and both count outputs are 0.
//
// The data-memory FSM state is observable on dmem_phase (RUN=0, PHASE2=1).
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      id_ir,
    input  logic             id_valid,
    input  logic [15:0]      ex_ir,
    input  logic             ex_valid,
    input  logic [15:0]      mem_ir,
    input  logic             mem_valid,
    input  logic             imem_resp,
    input  logic             dmem_resp,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_id_bubble,
    output logic             id_ex_load,
    output logic             id_ex_bubble,
    output logic             ex_mem_load,
    output logic             mem_wb_bubble,
    output logic             dmem_phase,
    output logic [CNT_W-1:0] lu_count,
    output logic [CNT_W-1:0] dmem_stall_count
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_PHASE2 = 1'b1;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_RTI = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_SHF = 4'b1101;

    logic       state;
    logic       state_next;
    logic [3:0] mem_opc;
    logic [3:0] ex_opc;
    logic [3:0] id_opc;
    logic       mem_single;
    logic       mem_double;
    logic       mem_op;
    logic       dmem_stall;
    logic       ex_is_load;
    logic [2:0] ex_dest;
    logic       need_sr1;
    logic       need_sr2;
    logic       need_sd;
    logic       load_use;
    logic       unused_bits;

    // Instruction fields that never influence a hazard decision.
    assign unused_bits = ^{id_ir[4:3], ex_ir[8:0], mem_ir[11:0]};

    assign mem_opc = mem_ir[15:12];
    assign ex_opc  = ex_ir[15:12];
    assign id_opc  = id_ir[15:12];
    assign ex_dest = ex_ir[11:9];

    // Classify the MEM-stage instruction and decide whether data memory stalls this cycle.
    always_comb begin
        mem_single = (mem_opc == OP_LDB) || (mem_opc == OP_LDR) ||
                     (mem_opc == OP_STB) || (mem_opc == OP_STR);
        mem_double = (mem_opc == OP_LDI) || (mem_opc == OP_STI);
        mem_op     = mem_valid && (mem_single || mem_double);
        dmem_stall = 1'b0;
        state_next = state;
        if (state == ST_PHASE2) begin
            // Second access of LDI/STI: finishes on its response regardless of the MEM word.
            dmem_stall = !dmem_resp;
            if (dmem_resp) begin
                state_next = ST_RUN;
            end
        end else if (mem_op) begin
            if (mem_double) begin
                // First access of a double op always holds the pipe for the second one.
                dmem_stall = 1'b1;
                if (dmem_resp) begin
                    state_next = ST_PHASE2;
                end
            end else begin
                dmem_stall = !dmem_resp;
            end
        end
    end

    // Decode which registers the ID instruction reads and compare with the EX load's destination.
    always_comb begin
        need_sr1 = 1'b0;
        need_sr2 = 1'b0;
        need_sd  = 1'b0;
        case (id_opc)
            OP_ADD, OP_AND: begin
                need_sr1 = 1'b1;
                need_sr2 = !id_ir[5];
            end
            OP_NOT, OP_SHF, OP_JMP, OP_LDB, OP_LDI, OP_LDR: need_sr1 = 1'b1;
            OP_JSR: need_sr1 = !id_ir[11];
            OP_STB, OP_STI, OP_STR: begin
                need_sr1 = 1'b1;
                need_sd  = 1'b1;
            end
            OP_RTI: begin
                need_sr1 = 1'b1;
                need_sr2 = 1'b1;
            end
            OP_BR:   need_sr1 = 1'b0;
            default: need_sr1 = 1'b0;
        endcase
        ex_is_load = (ex_opc == OP_LDB) || (ex_opc == OP_LDI) || (ex_opc == OP_LDR);
        load_use   = ex_valid && id_valid && ex_is_load &&
                     ((need_sr1 && (id_ir[8:6]  == ex_dest)) ||
                      (need_sr2 && (id_ir[2:0]  == ex_dest)) ||
                      (need_sd  && (id_ir[11:9] == ex_dest)));
    end

    // Priority-ordered stall controls: reset, data-memory stall, load-use, fetch wait.
    always_comb begin
        pc_load       = 1'b1;
        if_id_load    = 1'b1;
        if_id_bubble  = 1'b0;
        id_ex_load    = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_load   = 1'b1;
        mem_wb_bubble = 1'b0;
        dmem_phase    = 1'b0;
        if (!reset_n) begin
            pc_load       = 1'b0;
            if_id_load    = 1'b0;
            if_id_bubble  = 1'b1;
            id_ex_load    = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_load   = 1'b0;
            mem_wb_bubble = 1'b1;
        end else begin
            dmem_phase = state;
            if (dmem_stall) begin
                pc_load       = 1'b0;
                if_id_load    = 1'b0;
                id_ex_load    = 1'b0;
                ex_mem_load   = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID (the fetched word is kept, so no IF/ID bubble even
                // if fetch is also waiting) and push one NOP into EX.
                pc_load      = 1'b0;
                if_id_load   = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (!imem_resp) begin
                pc_load      = 1'b0;
                if_id_bubble = 1'b1;
            end
        end
    end

    // Data-memory FSM register; reset discards any outstanding second access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] ds_cnt;
    logic             lu_inc;

    assign lu_inc = load_use && !dmem_stall;

    // Saturating event counters for load-use bubbles and data-memory stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lu_cnt <= '0;
            ds_cnt <= '0;
        end else begin
            if (lu_inc && (lu_cnt != {CNT_W{1'b1}})) begin
                lu_cnt <= lu_cnt + 1'b1;
            end
            if (dmem_stall && (ds_cnt != {CNT_W{1'b1}})) begin
                ds_cnt <= ds_cnt + 1'b1;
            end
        end
    end

    assign lu_count         = lu_cnt;
    assign dmem_stall_count = ds_cnt;
`else
    assign lu_count         = '0;
    assign dmem_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vector table plus multi-cycle sequences for hazard_stall_ctrl.
// Expected control word layout: {pc_load, if_id_load, if_id_bubble, id_ex_load,
//                                id_ex_bubble, ex_mem_load, mem_wb_bubble, dmem_phase}
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 16;

    localparam logic [7:0] W_RUN   = 8'b1101_0100;
    localparam logic [7:0] W_LU    = 8'b0001_1100;
    localparam logic [7:0] W_IMEM  = 8'b0111_0100;
    localparam logic [7:0] W_DMEM  = 8'b0000_0010;
    localparam logic [7:0] W_RESET = 8'b0010_1010;

    logic             clk;
    logic             reset_n;
    logic [15:0]      id_ir;
    logic             id_valid;
    logic [15:0]      ex_ir;
    logic             ex_valid;
    logic [15:0]      mem_ir;
    logic             mem_valid;
    logic             imem_resp;
    logic             dmem_resp;
    logic             pc_load;
    logic             if_id_load;
    logic             if_id_bubble;
    logic             id_ex_load;
    logic             id_ex_bubble;
    logic             ex_mem_load;
    logic             mem_wb_bubble;
    logic             dmem_phase;
    logic [CNT_W-1:0] lu_count;
    logic [CNT_W-1:0] dmem_stall_count;

    int compared   = 0;
    int mismatched = 0;
    int exp_lu     = 0;
    int exp_ds     = 0;

    typedef struct {
        string       name;
        logic [15:0] id_ir;
        logic        id_valid;
        logic [15:0] ex_ir;
        logic        ex_valid;
        logic [15:0] mem_ir;
        logic        mem_valid;
        logic        imem_resp;
        logic        dmem_resp;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[18];

    hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_ir            (id_ir),
        .id_valid         (id_valid),
        .ex_ir            (ex_ir),
        .ex_valid         (ex_valid),
        .mem_ir           (mem_ir),
        .mem_valid        (mem_valid),
        .imem_resp        (imem_resp),
        .dmem_resp        (dmem_resp),
        .pc_load          (pc_load),
        .if_id_load       (if_id_load),
        .if_id_bubble     (if_id_bubble),
        .id_ex_load       (id_ex_load),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_load      (ex_mem_load),
        .mem_wb_bubble    (mem_wb_bubble),
        .dmem_phase       (dmem_phase),
        .lu_count         (lu_count),
        .dmem_stall_count (dmem_stall_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [15:0] i_ir, input logic i_v,
                                input logic [15:0] e_ir, input logic e_v,
                                input logic [15:0] m_ir, input logic m_v,
                                input logic im, input logic dm, input logic [7:0] e);
        vec_t v;
        v.name = n; v.id_ir = i_ir; v.id_valid = i_v; v.ex_ir = e_ir; v.ex_valid = e_v;
        v.mem_ir = m_ir; v.mem_valid = m_v; v.imem_resp = im; v.dmem_resp = dm; v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic [15:0] i_ir, input logic i_v,
                         input logic [15:0] e_ir, input logic e_v,
                         input logic [15:0] m_ir, input logic m_v,
                         input logic im, input logic dm);
        id_ir = i_ir; id_valid = i_v; ex_ir = e_ir; ex_valid = e_v;
        mem_ir = m_ir; mem_valid = m_v; imem_resp = im; dmem_resp = dm;
    endtask

    task automatic check_word(input string n, input logic [7:0] e);
        logic [7:0] act;
        act = {pc_load, if_id_load, if_id_bubble, id_ex_load,
               id_ex_bubble, ex_mem_load, mem_wb_bubble, dmem_phase};
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("FAIL %s: controls got %b expected %b", n, act, e);
        end
    endtask

    task automatic check_cnt(input string n);
        logic [CNT_W-1:0] e_lu;
        logic [CNT_W-1:0] e_ds;
`ifdef STALL_PERF_EN
        e_lu = CNT_W'(exp_lu);
        e_ds = CNT_W'(exp_ds);
`else
        e_lu = '0;
        e_ds = '0;
`endif
        compared++;
        if (lu_count !== e_lu) begin
            mismatched++;
            $display("FAIL %s lu_count: got %0d expected %0d", n, lu_count, e_lu);
        end
        compared++;
        if (dmem_stall_count !== e_ds) begin
            mismatched++;
            $display("FAIL %s dmem_stall_count: got %0d expected %0d", n, dmem_stall_count, e_ds);
        end
    endtask

    // Check the held inputs mid-cycle, then clock once and update the counter model.
    task automatic step(input string n, input logic [7:0] e);
        @(negedge clk);
        check_word(n, e);
        @(posedge clk);
        if (e[3]) exp_lu++;
        if (e[1]) exp_ds++;
        #1;
    endtask

    initial begin
        vecs[0]  = mk("idle",        16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, W_RUN);
        vecs[1]  = mk("lu_sr1",      16'h12C2, 1, 16'h6600, 1, 16'h0000, 0, 1, 1, W_LU);
        vecs[2]  = mk("imm_no_sr2",  16'h12A3, 1, 16'h6600, 1, 16'h0000, 0, 1, 1, W_RUN);
        vecs[3]  = mk("str_sd",      16'h7680, 1, 16'h6600, 1, 16'h0000, 0, 1, 1, W_LU);
        vecs[4]  = mk("ex_invalid",  16'h12C2, 1, 16'h6600, 0, 16'h0000, 0, 1, 1, W_RUN);
        vecs[5]  = mk("id_invalid",  16'h12C2, 0, 16'h6600, 1, 16'h0000, 0, 1, 1, W_RUN);
        vecs[6]  = mk("ex_not_load", 16'h12C2, 1, 16'h7600, 1, 16'h0000, 0, 1, 1, W_RUN);
        vecs[7]  = mk("lu_sr2",      16'h12C2, 1, 16'h2400, 1, 16'h0000, 0, 1, 1, W_LU);
        vecs[8]  = mk("jsr_imm",     16'h4880, 1, 16'h2400, 1, 16'h0000, 0, 1, 1, W_RUN);
        vecs[9]  = mk("jsrr",        16'h4080, 1, 16'h2400, 1, 16'h0000, 0, 1, 1, W_LU);
        vecs[10] = mk("ldi_in_ex",   16'h12C2, 1, 16'hA600, 1, 16'h0000, 0, 1, 1, W_LU);
        vecs[11] = mk("imem_wait",   16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, W_IMEM);
        vecs[12] = mk("imem_and_lu", 16'h12C2, 1, 16'h6600, 1, 16'h0000, 0, 0, 1, W_LU);
        vecs[13] = mk("stb_wait",    16'h0000, 0, 16'h0000, 0, 16'h3440, 1, 1, 0, W_DMEM);
        vecs[14] = mk("stb_done",    16'h0000, 0, 16'h0000, 0, 16'h3440, 1, 1, 1, W_RUN);
        vecs[15] = mk("mem_invalid", 16'h0000, 0, 16'h0000, 0, 16'h3440, 0, 1, 0, W_RUN);
        vecs[16] = mk("br_no_src",   16'h0000, 1, 16'h6000, 1, 16'h0000, 0, 1, 1, W_RUN);
        vecs[17] = mk("not_sr1",     16'h92FF, 1, 16'h6600, 1, 16'h0000, 0, 1, 1, W_LU);

        // Reset
        reset_n = 1'b0;
        drive(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 1);
        #1;
        check_word("reset", W_RESET);
        check_cnt("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].id_ir, vecs[i].id_valid, vecs[i].ex_ir, vecs[i].ex_valid,
                  vecs[i].mem_ir, vecs[i].mem_valid, vecs[i].imem_resp, vecs[i].dmem_resp);
            step(vecs[i].name, vecs[i].exp);
        end
        check_cnt("after_table");

        // Load-use: one bubble, then the load moves to MEM and the pipe flows
        drive(16'h12C2, 1, 16'h6600, 1, 16'h0000, 0, 1, 1);
        step("seq_lu_bubble", W_LU);
        drive(16'h12C2, 1, 16'h0000, 0, 16'h6600, 1, 1, 1);
        step("seq_lu_after", W_RUN);
        check_cnt("seq_lu");

        // LDI with dmem_resp 0,1,0,1
        drive(16'h0000, 0, 16'h0000, 0, 16'hA400, 1, 1, 0);
        step("ldi_c1", W_DMEM);
        dmem_resp = 1'b1;
        step("ldi_c2", W_DMEM);
        dmem_resp = 1'b0;
        step("ldi_c3", W_DMEM | 8'h01);
        dmem_resp = 1'b1;
        step("ldi_c4", W_RUN | 8'h01);
        drive(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 1);
        step("ldi_after", W_RUN);
        check_cnt("seq_ldi");

        // STB waiting on memory while a load-use hazard sits behind it
        drive(16'h12C2, 1, 16'h6600, 1, 16'h3440, 1, 1, 0);
        step("stb_lu_c1", W_DMEM);
        step("stb_lu_c2", W_DMEM);
        dmem_resp = 1'b1;
        step("stb_lu_c3", W_LU);
        drive(16'h12C2, 1, 16'h0000, 0, 16'h6600, 1, 1, 1);
        step("stb_lu_c4", W_RUN);
        check_cnt("seq_stb_lu");

        // Instruction memory wait for two cycles
        drive(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
        step("imem_c1", W_IMEM);
        step("imem_c2", W_IMEM);
        imem_resp = 1'b1;
        step("imem_c3", W_RUN);

        // Reset asserted in PHASE2
        drive(16'h0000, 0, 16'h0000, 0, 16'hA400, 1, 1, 1);
        step("p2_enter", W_DMEM);
        dmem_resp = 1'b0;
        step("p2_hold", W_DMEM | 8'h01);
        reset_n = 1'b0;
        exp_lu = 0;
        exp_ds = 0;
        #1;
        check_word("p2_reset", W_RESET);
        check_cnt("p2_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(16'h0000, 0, 16'h0000, 0, 16'h2000, 1, 1, 1);
        step("ldb_after_reset", W_RUN);
        check_cnt("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
